// File: rtl/t07_mmio_pkg.sv
// t07_mmio_pkg: shared states, sources, default address map and helpers for the MMIO router
package t07_mmio_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, WAIT, RESP} state_t;
  typedef enum logic {SRC_DATA, SRC_FETCH} src_t;
  localparam int TGT_REG = 0;
  localparam int TGT_TFT = 1;
  localparam int TGT_MEM = 2;
  localparam logic [31:0] REG_BASE = 32'h0000_0000;
  localparam logic [31:0] REG_LIMIT = 32'h0000_03FF;
  localparam logic [31:0] TFT_BASE = 32'h0000_0400;
  localparam logic [31:0] TFT_LIMIT = 32'h0000_07FF;
  localparam logic [31:0] MEM_BASE = 32'h0000_0800;
  localparam logic [31:0] MEM_LIMIT = 32'hFFFF_FFFF;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/t07_mmio_decode.sv
// t07_mmio_decode: lowest-index address match plus read/write permission lookup
module t07_mmio_decode import t07_mmio_pkg::*; #(
  parameter int AW = 32,
  parameter int NUM_TGT = 3,
  parameter logic [NUM_TGT*AW-1:0] TGT_BASE = {MEM_BASE, TFT_BASE, REG_BASE},
  parameter logic [NUM_TGT*AW-1:0] TGT_LIMIT = {MEM_LIMIT, TFT_LIMIT, REG_LIMIT},
  parameter logic [NUM_TGT-1:0] TGT_RD_EN = 3'b101,
  parameter logic [NUM_TGT-1:0] TGT_WR_EN = 3'b110
) (
  input  logic [AW-1:0]               addr,
  input  logic                        we,
  output logic [idx_w(NUM_TGT)-1:0]   sel,
  output logic                        hit,
  output logic                        perm_ok
);
  localparam int SW = idx_w(NUM_TGT);
  always_comb begin
    sel = '0;
    hit = 1'b0;
    perm_ok = 1'b0;
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if (addr - TGT_BASE[i*AW +: AW] <= TGT_LIMIT[i*AW +: AW] - TGT_BASE[i*AW +: AW]) begin
        sel = SW'(i);
        hit = 1'b1;
        perm_ok = we ? TGT_WR_EN[i] : TGT_RD_EN[i];
      end
    end
  end
endmodule

// File: rtl/t07_mmio_router.sv
// t07_mmio_router: round-robin data/fetch arbiter routing one transaction at a time to req/ack targets
module t07_mmio_router import t07_mmio_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NUM_TGT = 3,
  parameter logic [NUM_TGT*AW-1:0] TGT_BASE = {MEM_BASE, TFT_BASE, REG_BASE},
  parameter logic [NUM_TGT*AW-1:0] TGT_LIMIT = {MEM_LIMIT, TFT_LIMIT, REG_LIMIT},
  parameter logic [NUM_TGT-1:0] TGT_RD_EN = 3'b101,
  parameter logic [NUM_TGT-1:0] TGT_WR_EN = 3'b110,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic                  d_we,
  input  logic [AW-1:0]         d_addr,
  input  logic [DW-1:0]         d_wdata,
  output logic                  d_done,
  output logic [DW-1:0]         d_rdata,
  output logic                  d_err,
  input  logic                  f_valid,
  output logic                  f_ready,
  input  logic [AW-1:0]         f_addr,
  output logic                  f_done,
  output logic [DW-1:0]         f_inst,
  output logic                  f_err,
  output logic [NUM_TGT-1:0]    tgt_req,
  output logic                  tgt_we,
  output logic [AW-1:0]         tgt_addr,
  output logic [DW-1:0]         tgt_wdata,
  input  logic [NUM_TGT-1:0]    tgt_ack,
  input  logic [NUM_TGT*DW-1:0] tgt_rdata,
  output logic                  busy
);
  localparam int SW = idx_w(NUM_TGT);
  localparam int CW = $clog2(TIMEOUT);
  state_t state;
  src_t src, last_grant;
  logic [SW-1:0] sel, dec_sel;
  logic [CW-1:0] cnt;
  logic hit, perm_ok, gnt_d, gnt_f, ack, tmo, fin, fin_err, go;
  logic [DW-1:0] fin_data;
  t07_mmio_decode #(
    .AW(AW), .NUM_TGT(NUM_TGT), .TGT_BASE(TGT_BASE), .TGT_LIMIT(TGT_LIMIT),
    .TGT_RD_EN(TGT_RD_EN), .TGT_WR_EN(TGT_WR_EN)
  ) u_dec (
    .addr(tgt_addr), .we(tgt_we), .sel(dec_sel), .hit(hit), .perm_ok(perm_ok)
  );
  assign gnt_d = state == IDLE && d_valid && (!f_valid || last_grant == SRC_FETCH);
  assign gnt_f = state == IDLE && f_valid && !gnt_d;
  assign d_ready = gnt_d;
  assign f_ready = gnt_f;
  assign busy = state != IDLE;
  assign go = hit && perm_ok;
  assign ack = tgt_ack[sel];
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign fin = (state == DECODE && !go) || (state == WAIT && (ack || tmo));
  assign fin_err = state == DECODE || !ack;
  assign fin_data = (state == WAIT && ack && !tgt_we) ? tgt_rdata[sel*DW +: DW] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= SRC_DATA;
      last_grant <= SRC_FETCH;
      sel <= '0;
      cnt <= '0;
      tgt_req <= '0;
      tgt_we <= 1'b0;
      tgt_addr <= '0;
      tgt_wdata <= '0;
      d_done <= 1'b0;
      d_rdata <= '0;
      d_err <= 1'b0;
      f_done <= 1'b0;
      f_inst <= '0;
      f_err <= 1'b0;
    end else begin
      d_done <= fin && src == SRC_DATA;
      d_err <= fin && fin_err && src == SRC_DATA;
      d_rdata <= (fin && src == SRC_DATA) ? fin_data : '0;
      f_done <= fin && src == SRC_FETCH;
      f_err <= fin && fin_err && src == SRC_FETCH;
      f_inst <= (fin && src == SRC_FETCH) ? fin_data : '0;
      case (state)
        IDLE: if (gnt_d || gnt_f) begin
          src <= gnt_d ? SRC_DATA : SRC_FETCH;
          last_grant <= gnt_d ? SRC_DATA : SRC_FETCH;
          tgt_we <= gnt_d && d_we;
          tgt_addr <= gnt_d ? d_addr : f_addr;
          tgt_wdata <= gnt_d ? d_wdata : '0;
          state <= DECODE;
        end
        DECODE: begin
          sel <= dec_sel;
          cnt <= '0;
          tgt_req <= go ? NUM_TGT'(1) << dec_sel : '0;
          state <= go ? WAIT : RESP;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (ack || tmo) begin
            tgt_req <= '0;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/t07_mmio_router.md
Name: t07_mmio_router

Overview:
Parametrised, sequential successor to the combinational MMIO decoder. Two requesters, the CPU data port and the instruction-fetch port, arbitrate for one shared transaction path. Each request is routed to one of NUM_TGT external targets through an explicit req/ack handshake. Adds per-target read/write permissions, a timeout, an error response and round-robin arbitration. Sits between the CPU memory handler/fetch unit and the external register, SPI TFT and wishbone instruction/data memory.

Parameters:
AW, 32, address width
DW, 32, data width
NUM_TGT, 3, number of targets
TGT_BASE, {32'h0800, 32'h0400, 32'h0000}, flattened NUM_TGT*AW inclusive base per target (index 0 in LSBs)
TGT_LIMIT, {32'hFFFF_FFFF, 32'h07FF, 32'h03FF}, flattened NUM_TGT*AW inclusive limit per target
TGT_RD_EN, 3'b101, per-target read permitted
TGT_WR_EN, 3'b110, per-target write permitted
TIMEOUT, 255, max cycles waiting for ack (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
d_valid  in  1  data request valid, held until d_ready
d_ready  out  1  data request accepted this cycle
d_we  in  1  1=write, 0=read
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_done  out  1  one-cycle completion pulse to data port
d_rdata  out  DW  read data, valid with d_done
d_err  out  1  error flag, valid with d_done
f_valid  in  1  fetch request valid, held until f_ready
f_ready  out  1  fetch request accepted
f_addr  in  AW  fetch address (read only)
f_done  out  1  fetch completion pulse
f_inst  out  DW  instruction, valid with f_done
f_err  out  1  fetch error, valid with f_done
tgt_req  out  NUM_TGT  one-hot request, held until ack
tgt_we  out  1  write strobe to selected target
tgt_addr  out  AW  latched address
tgt_wdata  out  DW  latched write data
tgt_ack  in  NUM_TGT  per-target ack, one cycle
tgt_rdata  in  NUM_TGT*DW  per-target read data, sampled on ack
busy  out  1  high when state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. On rst, state=IDLE, all outputs 0, timeout counter 0, last_grant=FETCH so that data wins the first tie. rst mid-transaction drops tgt_req at the next edge with no done pulse.
- FSM states: IDLE, DECODE, WAIT, RESP.
- IDLE:
  - d_ready/f_ready are combinational and may be high only in IDLE.
  - With one valid, grant it.
  - With both valid, grant the port not in last_grant (round-robin).
  - On grant, latch addr, we (fetch forces 0), wdata and source; update last_grant; go to DECODE.
- DECODE (1 cycle):
  - sel = lowest index i with TGT_BASE[i] <= addr <= TGT_LIMIT[i]. Overlapping regions resolve to the lowest index.
  - No match, read to a target with TGT_RD_EN[i]=0, or write to a target with TGT_WR_EN[i]=0 -> RESP with err=1, rdata=0. No tgt_req is issued.
  - Otherwise go to WAIT with the counter cleared.
- WAIT:
  - tgt_req[sel]=1, with tgt_we/tgt_addr/tgt_wdata stable.
  - tgt_ack[sel] -> capture tgt_rdata slice sel (writes capture 0), err=0, go to RESP.
  - Counter increments every WAIT cycle. Counter reaching TIMEOUT-1 without ack -> err=1, rdata=0, go to RESP.
  - Ack on the timeout cycle: ack wins.
  - Acks on unselected bits, or outside WAIT, are ignored.
- RESP (1 cycle): pulse d_done or f_done for the latched source, together with its rdata/err, then return to IDLE. The other port's done/err/rdata stay 0.
- Latency: request accepted at edge 0; tgt_req high from cycle 2. Ack in cycle k -> done in cycle k+1. Minimum 4 cycles from accept to done (ack in the first WAIT cycle); an error response takes 3 cycles.
- Throughput and outputs: one transaction in flight; no pipelining. All outputs are registered except d_ready/f_ready/busy.

Decomposition:
- Package t07_mmio_pkg:
  - state enum {IDLE, DECODE, WAIT, RESP}
  - source enum {SRC_DATA, SRC_FETCH}
  - default-map localparams: TGT_REG=0, TGT_TFT=1, TGT_MEM=2, plus their base/limit constants.
- Sub-module t07_mmio_decode: combinational address/permission decoder producing sel index, hit and perm_ok. Parametrised by AW, NUM_TGT, TGT_BASE, TGT_LIMIT, TGT_RD_EN, TGT_WR_EN.

Test Plan:
- Data read 0x0010, tgt_ack[0] two cycles after tgt_req rises with rdata0=0xDEAD_BEEF -> tgt_req=3'b001, d_done one cycle after ack, d_rdata=0xDEADBEEF, d_err=0.
- Data write 0x0400 with 0x1234_5678 -> tgt_req=3'b010, tgt_we=1, tgt_wdata=0x12345678 until ack; write to 0x0010 -> no tgt_req, d_err=1 three cycles after accept.
- d_valid and f_valid asserted together, held, from reset -> data granted first, fetch next; two simultaneous streams alternate D,F,D,F.
- Fetch 0x2000, no ack -> tgt_req=3'b100 for exactly TIMEOUT cycles, then f_done=1, f_err=1, f_inst=0; ack arriving on the final WAIT cycle -> f_err=0.
- rst asserted during WAIT -> tgt_req=0, busy=0 next cycle, no done pulse; a later request completes normally.
- Stray tgt_ack[1] while IDLE or during a target-0 WAIT -> ignored, no done, no state change.
